// File: rtl/conv_result_writer_if.sv
// Bus between the 2-D conv write-back controller and its environment.
// Handshake: the environment raises done_conv with conv_result valid in the
// same cycle; the controller acts once per 0->1 transition (no backpressure,
// a held level counts once). On the BRAM side we/wr_ack are one-cycle pulses
// and waddr/wdata are valid whenever we=1, holding their value otherwise.
interface conv_result_writer_if #(
  parameter int RES_W  = 20,
  parameter int ADDR_W = 14
);
  logic                     start;
  logic                     done_conv;
  logic signed [RES_W-1:0]  conv_result;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [7:0]               wdata;
  logic                     wr_ack;
  logic                     busy;
  logic                     frame_done;
  logic [15:0]              sat_count;
  logic [1:0]               state_dbg;

  modport master (
    output start, done_conv, conv_result,
    input  we, waddr, wdata, wr_ack, busy, frame_done, sat_count, state_dbg
  );

  modport slave (
    input  start, done_conv, conv_result,
    output we, waddr, wdata, wr_ack, busy, frame_done, sat_count, state_dbg
  );
endinterface

// File: rtl/conv_result_writer.sv
// Write-back controller: clamps each signed conv result to an 8-bit pixel and
// writes it row-major into a IMG_W x IMG_H output BRAM, one write per
// done_conv rising edge, then pulses frame_done after the last pixel.
module conv_result_writer #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int RES_W  = 20,
  parameter int ADDR_W = 14
) (
  input  logic clk,
  input  logic rst,
  conv_result_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]       IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]       COL_MAX = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]       ROW_MAX = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]       ONE_A   = ADDR_W'(1);
  localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'(255);

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        row, col;
  logic                     done_d;
  logic                     pend;
  logic signed [RES_W-1:0]  res_q;
  logic [ADDR_W-1:0]        waddr_q;
  logic [7:0]               wdata_q;
  logic [15:0]              sat_q;

  logic                     rise;
  logic                     start_frame;
  logic                     issue;
  logic                     advance;
  logic                     set_pend;
  logic                     last_pix;
  logic signed [RES_W-1:0]  res_sel;
  logic [7:0]               pix;
  logic                     sat;

  assign rise     = bus.done_conv & ~done_d;
  assign last_pix = (row == ROW_MAX) && (col == COL_MAX);

  // Pixel clamp on the value that is about to be written: a pending result
  // was already latched, otherwise take the result on the bus this cycle.
  always_comb begin
    res_sel = pend ? res_q : bus.conv_result;
    pix     = res_sel[7:0];
    sat     = 1'b0;
    if (res_sel[RES_W-1]) begin
      pix = 8'd0;
      sat = 1'b1;
    end else if (res_sel > PIX_MAX) begin
      pix = 8'hFF;
      sat = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    issue       = 1'b0;
    advance     = 1'b0;
    set_pend    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          start_frame = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise || pend) begin
          issue     = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        advance = 1'b1;
        if (last_pix) begin
          // Frame is full; any edge arriving now has no pixel slot.
          state_nxt = S_DONE;
        end else begin
          set_pend  = rise;
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge history, pixel counters, pending result, write registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_d  <= 1'b0;
      row     <= '0;
      col     <= '0;
      pend    <= 1'b0;
      res_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      sat_q   <= '0;
    end else begin
      done_d <= bus.done_conv;
      if (start_frame) begin
        row   <= '0;
        col   <= '0;
        pend  <= 1'b0;
        sat_q <= '0;
      end
      if (issue) begin
        res_q   <= res_sel;
        pend    <= 1'b0;
        waddr_q <= row * IMG_W_A + col;
        wdata_q <= pix;
        if (sat && (sat_q != 16'hFFFF)) sat_q <= sat_q + 16'd1;
      end
      if (advance) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + ONE_A;
        end else begin
          col <= col + ONE_A;
        end
      end
      if (set_pend) begin
        res_q <= bus.conv_result;
        pend  <= 1'b1;
      end
    end
  end

  assign bus.we         = (state == S_WRITE);
  assign bus.wr_ack     = (state == S_WRITE);
  assign bus.frame_done = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.sat_count  = sat_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: directed writes, clamping, held level,
// mid-frame reset and a full random frame, checked against an expected queue.
module tb_conv_result_writer;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int RES_W  = 20;
  localparam int ADDR_W = 14;
  localparam int NPIX   = IMG_W * IMG_H;

  logic clk;
  logic rst;

  conv_result_writer_if #(.RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

  conv_result_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .RES_W(RES_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [15:0]       exp_sat;
  int                total;
  int                bad;
  int                we_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input int val);
    if (val < 0)   return 8'd0;
    if (val > 255) return 8'd255;
    return val[7:0];
  endfunction

  // Monitor: every write pops one expected {addr,data} entry.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        check("waddr",  32'(bus.waddr),  32'(e[ADDR_W+7:8]));
        check("wdata",  32'(bus.wdata),  32'(e[7:0]));
        check("wr_ack", 32'(bus.wr_ack), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},         32'(bus.we),         32'd0);
    check({tag, "_wr_ack"},     32'(bus.wr_ack),     32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_waddr"},      32'(bus.waddr),      32'd0);
    check({tag, "_wdata"},      32'(bus.wdata),      32'd0);
    check({tag, "_sat_count"},  32'(bus.sat_count),  32'd0);
  endtask

  task automatic start_frame();
    exp_addr  = '0;
    exp_sat   = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // One result per rising edge; done_conv high for a cycle then low.
  task automatic send(input int val, input bit chk_lat);
    exp_q.push_back({exp_addr, model_pix(val)});
    exp_addr = exp_addr + 1'b1;
    if ((val < 0 || val > 255) && exp_sat != 16'hFFFF) exp_sat++;
    bus.conv_result = RES_W'(val);
    bus.done_conv   = 1'b1;
    @(posedge clk); #1;
    if (chk_lat) check("we_latency", 32'(bus.we), 32'd1);
    bus.done_conv = 1'b0;
    @(posedge clk); #1;
    if (chk_lat) check("we_gap", 32'(bus.we), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wc;
    total = 0; bad = 0; we_count = 0;
    exp_addr = '0; exp_sat = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.done_conv = 1'b0;
    bus.conv_result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single write
    start_frame();
    send(100, 1'b1);
    check("sat_single", 32'(bus.sat_count), 32'd0);

    // Clamp on a fresh frame
    do_reset();
    start_frame();
    send(-5, 1'b1);
    send(300, 1'b1);
    send(255, 1'b1);
    check("sat_clamp", 32'(bus.sat_count), 32'd2);

    // Held level gives one write
    wc = we_count;
    exp_q.push_back({exp_addr, 8'd42});
    exp_addr = exp_addr + 1'b1;
    bus.conv_result = RES_W'(42);
    bus.done_conv = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.done_conv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("held_level_writes", 32'(we_count - wc), 32'd1);

    // Start outside IDLE is ignored: address stream continues
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send(9, 1'b1);

    // Reset mid-frame
    do_reset();
    start_frame();
    for (int i = 0; i < 50; i++) send($urandom_range(0, 255), 1'b0);
    check("q_empty_pre_reset", 32'(exp_q.size()), 32'd0);
    do_reset();
    check_reset_outputs("midreset");
    wc = we_count;
    bus.conv_result = RES_W'(77);
    bus.done_conv = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.done_conv = 1'b0;
    @(posedge clk); #1;
    check("no_write_after_reset", 32'(we_count - wc), 32'd0);
    start_frame();
    send(7, 1'b1);

    // Full frame with random results (row wrap covered by the scoreboard)
    do_reset();
    start_frame();
    for (int i = 0; i < NPIX; i++) begin
      int v;
      v = int'($urandom_range(0, 700)) - 200;
      send(v, (i == NPIX - 1) || (i == IMG_W) || (i == IMG_W - 1));
    end
    check("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    check("busy_in_done",     32'(bus.busy),       32'd1);
    check("sat_frame",        32'(bus.sat_count),  32'(exp_sat));
    @(posedge clk); #1;
    check("frame_done_clear", 32'(bus.frame_done), 32'd0);
    check("busy_after_frame", 32'(bus.busy),       32'd0);
    wc = we_count;
    bus.conv_result = RES_W'(50);
    bus.done_conv = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.done_conv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("no_write_after_frame", 32'(we_count - wc), 32'd0);
    check("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
